// File: rtl/sorted_frame_checker_if.sv
// Sample stream bundle: data plus valid/ready handshake and first/last frame delimiters.
interface samples_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  first;
    logic                  last;

    modport source (output data, valid, first, last, input ready);
    modport sink   (input data, valid, first, last, output ready);
    modport master (output data, valid, first, last, input ready);
    modport slave  (input data, valid, first, last, output ready);
endinterface

// File: rtl/sorted_frame_checker.sv
// Frame sink that checks ordering, sample count and additive checksum per frame.
// Optional CHK_RANDOM_STALL_EN adds LFSR-driven backpressure on ready.
module sorted_frame_checker #(
    parameter int          DATA_WIDTH     = 8,
    parameter int          MEM_ADDR_WIDTH = 4,
    parameter int          SUM_W          = DATA_WIDTH + MEM_ADDR_WIDTH + 1,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    samples_if.sink                 inputSamples,
    input  logic                    expValid,
    input  logic [MEM_ADDR_WIDTH:0] expCount,
    input  logic [SUM_W-1:0]        expSum,
    output logic                    frameDone,
    output logic                    frameOk,
    output logic [5:0]              errFlags,
    output logic                    stickyErr,
    output logic [15:0]             frameCount,
    output logic [MEM_ADDR_WIDTH:0] rxCount
);
    localparam logic [MEM_ADDR_WIDTH:0] MAX_CNT = {1'b1, {MEM_ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, FRAME, REPORT} state_t;

    state_t                  state, state_nxt;
    logic                    rdy, accept, stall;
    logic [DATA_WIDTH-1:0]   prev;
    logic [SUM_W-1:0]        sum, cur_sum, slot_sum;
    logic [MEM_ADDR_WIDTH:0] cur_count, slot_count;
    logic [5:0]              flags, rpt_flags;
    logic                    rpt_vld;

    assign accept             = inputSamples.valid && rdy;
    assign inputSamples.ready = rdy;

`ifdef CHK_RANDOM_STALL_EN
    logic [15:0] lfsr, lfsr_nxt;
    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    // ready is registered, so gate it with the LFSR value of the cycle it will be seen in
    assign stall    = (lfsr_nxt[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= lfsr_nxt;
    end
`else
    assign stall = 1'b0 & ^LFSR_SEED;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && inputSamples.first) state_nxt = inputSamples.last ? REPORT : FRAME;
            FRAME:   if (accept && inputSamples.last)  state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rdy        <= 1'b0;
            prev       <= '0;
            sum        <= '0;
            cur_sum    <= '0;
            slot_sum   <= '0;
            cur_count  <= '0;
            slot_count <= '0;
            flags      <= '0;
            rpt_flags  <= '0;
            rpt_vld    <= 1'b0;
            frameDone  <= 1'b0;
            frameOk    <= 1'b0;
            errFlags   <= '0;
            stickyErr  <= 1'b0;
            frameCount <= '0;
            rxCount    <= '0;
        end else begin
            state <= state_nxt;
            rdy   <= !stall && (state_nxt != REPORT);

            if (expValid) begin
                slot_count <= expCount;
                slot_sum   <= expSum;
            end

            // verdict is staged one cycle after REPORT so frameDone lands two edges after last
            rpt_vld   <= 1'b0;
            frameDone <= rpt_vld;
            if (rpt_vld) begin
                frameOk    <= (rpt_flags == 6'b0);
                errFlags   <= rpt_flags;
                stickyErr  <= stickyErr | (|rpt_flags);
                frameCount <= frameCount + 16'd1;
            end

            case (state)
                IDLE: if (accept) begin
                    if (inputSamples.first) begin
                        rxCount   <= {{MEM_ADDR_WIDTH{1'b0}}, 1'b1};
                        sum       <= SUM_W'(inputSamples.data);
                        prev      <= inputSamples.data;
                        cur_count <= expValid ? expCount : slot_count;
                        cur_sum   <= expValid ? expSum   : slot_sum;
                    end else begin
                        flags[0] <= 1'b1;
                    end
                end
                FRAME: if (accept) begin
                    if (rxCount == MAX_CNT) flags[5] <= 1'b1;
                    else                    rxCount  <= rxCount + 1'b1;
                    sum  <= sum + SUM_W'(inputSamples.data);
                    prev <= inputSamples.data;
                    if (inputSamples.data < prev) flags[1] <= 1'b1;
                    if (inputSamples.first)       flags[2] <= 1'b1;
                end
                REPORT: begin
                    rpt_vld   <= 1'b1;
                    rpt_flags <= flags | {1'b0, sum != cur_sum, rxCount != cur_count, 3'b000};
                    flags     <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
